// File: rtl/otter_cu_fsm_dcdr.sv
// OTTER multicycle control FSM + full-IR decoder with prioritised, edge-latched interrupts.
// Optional RV32M handshake (md_start/md_sel/md_done, MD_WAIT state) is built when OTTER_MEXT_EN is defined.
module otter_cu_fsm_dcdr #(
  parameter int NUM_IRQ = 1,
  parameter int MEM_LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          ir,
  input  logic                 br_eq,
  input  logic                 br_lt,
  input  logic                 br_ltu,
  input  logic [NUM_IRQ-1:0]   intr,
  input  logic                 mie,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic                 mem_we2,
  output logic                 mem_rden1,
  output logic                 mem_rden2,
  output logic                 csr_we,
  output logic                 int_taken,
  output logic                 mret_exec,
  output logic                 illegal_instr,
  output logic [3:0]           alu_fun,
  output logic [1:0]           alu_srcA,
  output logic [2:0]           alu_srcB,
  output logic [2:0]           pcSource,
  output logic [1:0]           rf_wr_sel,
  output logic [((NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1)-1:0] irq_cause,
`ifdef OTTER_MEXT_EN
  output logic                 md_start,
  output logic                 md_sel,
  input  logic                 md_done,
`endif
  output logic [2:0]           dbg_state_o
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH      = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_EXEC       = 3'd2,
    S_LD_WAIT    = 3'd3,
    S_INTR       = 3'd4,
    S_MD_WAIT    = 3'd5
  } state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic [NUM_IRQ-1:0] pending_q;
  logic [NUM_IRQ-1:0] intr_prev_q;
  logic [IW-1:0]      irq_cause_q;

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               f7;
  logic               is_load;
  logic               is_md;
  logic               br_taken;
  logic [NUM_IRQ-1:0] edge_w;
  logic [NUM_IRQ-1:0] pend_now;
  logic [NUM_IRQ-1:0] clr_mask;
  logic               irq_go;
  logic [IW-1:0]      low_idx;
  logic               unused_ir;

  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign f7        = ir[30];
  assign is_load   = (opcode == OP_LOAD);
  assign is_md     = (opcode == OP_R) && (ir[31:25] == 7'b0000001);
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  // Edges seen this cycle count as pending already, so a request arriving during
  // EXEC is taken right after it; in INTR a fresh edge re-sets the bit being cleared.
  assign edge_w   = intr & ~intr_prev_q;
  assign pend_now = pending_q | edge_w;
  assign irq_go   = mie && (pend_now != '0);
  assign clr_mask = NUM_IRQ'(1) << irq_cause_q;

  always_comb begin
    low_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend_now[i]) low_idx = IW'(i);
    end
  end

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = !br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = !br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    reg_write     = 1'b0;
    mem_we2       = 1'b0;
    mem_rden1     = 1'b0;
    mem_rden2     = 1'b0;
    csr_we        = 1'b0;
    int_taken     = 1'b0;
    mret_exec     = 1'b0;
    illegal_instr = 1'b0;
    alu_fun       = 4'd0;
    alu_srcA      = 2'd0;
    alu_srcB      = 3'd0;
    pcSource      = 3'd0;
    rf_wr_sel     = 2'd0;
`ifdef OTTER_MEXT_EN
    md_start      = 1'b0;
    md_sel        = 1'b0;
`endif
    if (!RST) begin
      case (state_q)
        S_FETCH: mem_rden1 = 1'b1;
        S_EXEC: begin
          pc_write = 1'b1;
          case (opcode)
            OP_R: begin
              if (is_md) begin
`ifdef OTTER_MEXT_EN
                md_start = 1'b1;
`else
                illegal_instr = 1'b1;
`endif
              end else begin
                reg_write = 1'b1;
                rf_wr_sel = 2'd3;
                alu_fun   = {f7, funct3};
              end
            end
            OP_IMM: begin
              reg_write = 1'b1;
              rf_wr_sel = 2'd3;
              alu_srcB  = 3'd1;
              alu_fun   = (funct3 == 3'b101) ? {f7, funct3} : {1'b0, funct3};
            end
            OP_LUI: begin
              alu_srcA  = 2'd1;
              alu_fun   = 4'b1001;
              reg_write = 1'b1;
              rf_wr_sel = 2'd3;
            end
            OP_AUIPC: begin
              alu_srcA  = 2'd1;
              alu_srcB  = 3'd3;
              reg_write = 1'b1;
              rf_wr_sel = 2'd3;
            end
            OP_JAL: begin
              pcSource  = 3'd3;
              reg_write = 1'b1;
            end
            OP_JALR: begin
              pcSource  = 3'd1;
              reg_write = 1'b1;
            end
            OP_LOAD: begin
              alu_srcB  = 3'd1;
              mem_rden2 = 1'b1;
            end
            OP_STORE: begin
              alu_srcB = 3'd2;
              mem_we2  = 1'b1;
            end
            OP_BRANCH: pcSource = br_taken ? 3'd2 : 3'd0;
            OP_SYS: begin
              case (funct3)
                3'b000: begin
                  pcSource  = 3'd5;
                  mret_exec = 1'b1;
                end
                3'b001, 3'b010, 3'b011: begin
                  csr_we    = 1'b1;
                  reg_write = 1'b1;
                  rf_wr_sel = 2'd1;
                  alu_fun   = (funct3 == 3'b001) ? 4'b1001 :
                              (funct3 == 3'b010) ? 4'b0110 : 4'b0111;
                  alu_srcB  = (funct3 == 3'b001) ? 3'd0 : 3'd4;
                  alu_srcA  = (funct3 == 3'b011) ? 2'd2 : 2'd0;
                end
                default: ;
              endcase
            end
            default: illegal_instr = 1'b1;
          endcase
        end
        S_LD_WAIT: begin
          if (cnt_q == '0) begin
            reg_write = 1'b1;
            rf_wr_sel = 2'd2;
            alu_srcB  = 3'd1;
          end
        end
        S_INTR: begin
          int_taken = 1'b1;
          pc_write  = 1'b1;
          pcSource  = 3'd4;
        end
`ifdef OTTER_MEXT_EN
        S_MD_WAIT: begin
          if (md_done) begin
            reg_write = 1'b1;
            rf_wr_sel = 2'd3;
            md_sel    = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign irq_cause   = RST ? '0 : irq_cause_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_FETCH;
      cnt_q       <= '0;
      pending_q   <= '0;
      intr_prev_q <= '0;
      irq_cause_q <= '0;
    end else begin
      intr_prev_q <= intr;
      pending_q   <= pend_now;
      case (state_q)
        S_FETCH: begin
          if (MEM_LAT == 1) begin
            state_q <= S_EXEC;
          end else begin
            cnt_q   <= CW'(MEM_LAT - 1);
            state_q <= S_FETCH_WAIT;
          end
        end
        S_FETCH_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (is_load) begin
            cnt_q   <= CW'(MEM_LAT - 1);
            state_q <= S_LD_WAIT;
          end
`ifdef OTTER_MEXT_EN
          else if (is_md) state_q <= S_MD_WAIT;
`endif
          else if (irq_go) begin
            state_q     <= S_INTR;
            irq_cause_q <= low_idx;
          end else state_q <= S_FETCH;
        end
        S_LD_WAIT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          else if (irq_go) begin
            state_q     <= S_INTR;
            irq_cause_q <= low_idx;
          end else state_q <= S_FETCH;
        end
`ifdef OTTER_MEXT_EN
        S_MD_WAIT: begin
          if (md_done) begin
            if (irq_go) begin
              state_q     <= S_INTR;
              irq_cause_q <= low_idx;
            end else state_q <= S_FETCH;
          end
        end
`endif
        S_INTR: begin
          pending_q <= (pending_q & ~clr_mask) | edge_w;
          state_q   <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: doc/otter_cu_fsm_dcdr.md
Name: otter_cu_fsm_dcdr

Overview:
- Merged multicycle control FSM and instruction decoder for the OTTER MCU.
- Sequences fetch, execute, load-writeback and interrupt entry.
- Drives the datapath mux selects and write strobes from the full 32-bit IR.
- Generalised over interrupt line count (prioritised, edge-latched) and memory read latency.

Parameters:
- NUM_IRQ, 1, number of external interrupt lines; index 0 has highest priority.
- MEM_LAT, 1, cycles from a read strobe to valid data (≥1), applies to fetch and load.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- ir  in  32  current instruction (valid from EXEC onward).
- br_eq, br_lt, br_ltu  in  1 each  branch comparator flags.
- intr  in  NUM_IRQ  interrupt request lines, level inputs.
- mie  in  1  global interrupt enable from the CSR file.
- pc_write, reg_write, mem_we2, mem_rden1, mem_rden2, csr_we  out  1 each  datapath strobes.
- int_taken  out  1  trap entry pulse.
- mret_exec  out  1  MRET pulse.
- illegal_instr  out  1  undecodable opcode pulse.
- alu_fun  out  4, alu_srcA  out  2, alu_srcB  out  3, pcSource  out  3, rf_wr_sel  out  2  mux selects.
- irq_cause  out  max(1,$clog2(NUM_IRQ))  index of the serviced line; held until the next trap.
- md_start  out  1, md_sel  out  1, md_done  in  1  present only with OTTER_MEXT_EN.

Behaviour:
- States: FETCH, FETCH_WAIT, EXEC, LD_WAIT, INTR (+ MD_WAIT with the optional feature).
- Reset (RST high at a CLK edge):
  - state goes to FETCH; pending register, latency counter, irq_cause and intr edge-detect history all clear to 0.
  - While RST is high, every output is forced to 0.
- FETCH: mem_rden1=1 for one cycle.
  - MEM_LAT=1: go to EXEC.
  - Otherwise go to FETCH_WAIT, load the counter with MEM_LAT-1, decrement each cycle, and go to EXEC when it reaches 0.
- EXEC (one cycle): decode opcode=ir[6:0], funct3=ir[14:12], f7=ir[30]. pc_write=1 for every instruction.
  - R-type (0110011): reg_write=1, rf_wr_sel=3, alu_fun={f7,funct3}.
  - OP-IMM (0010011): reg_write=1, rf_wr_sel=3, srcB=1; alu_fun={f7,funct3} when funct3=101, else {0,funct3}.
  - LUI: srcA=1, alu_fun=1001, reg_write=1, rf_wr_sel=3.
  - AUIPC: srcA=1, srcB=3, reg_write=1, rf_wr_sel=3.
  - JAL: pcSource=3, reg_write=1, rf_wr_sel=0.
  - JALR: pcSource=1, reg_write=1, rf_wr_sel=0.
  - LOAD: srcB=1, mem_rden2=1; go to LD_WAIT.
  - STORE: srcB=2, mem_we2=1.
  - BRANCH: pcSource=2 when taken, else 0.
    - Taken: BEQ br_eq; BNE !br_eq; BLT br_lt; BGE !br_lt; BLTU br_ltu; BGEU !br_ltu.
    - funct3 010/011 are never taken.
  - SYSTEM:
    - funct3=000: MRET, pcSource=5, mret_exec=1.
    - 001 CSRRW: csr_we=1, reg_write=1, rf_wr_sel=1, alu_fun=1001.
    - 010 CSRRS: same strobes, srcB=4, alu_fun=0110.
    - 011 CSRRC: same strobes, srcA=2, srcB=4, alu_fun=0111.
    - Other funct3 values: NOP.
  - Any other opcode: illegal_instr=1, pcSource=0, no other write (NOP).
- EXEC next state: LOAD goes to LD_WAIT. Otherwise, if (pending & mie) is non-zero, go to INTR; else go to FETCH.
- LD_WAIT: count MEM_LAT cycles.
  - On the final cycle: reg_write=1, rf_wr_sel=2, srcB=1.
  - Then go to INTR if an interrupt is pending and enabled, else FETCH.
- Interrupt latch: per line, a rising edge of intr[i] (0 last cycle, 1 this cycle) sets pending[i].
  - Pending bits persist while mie=0.
  - A clear and a new edge on the same line in the same cycle: set wins.
- INTR (one cycle): int_taken=1, pc_write=1, pcSource=4.
  - irq_cause is registered as the lowest set index of pending.
  - That pending bit clears; next state is FETCH.
- Interrupts never preempt mid-instruction. They are only taken after EXEC or LD_WAIT completes.

Optional Feature:
- OTTER_MEXT_EN (RV32M decode).
- With the macro:
  - R-type with ir[31:25]=0000001 asserts md_start=1 in EXEC (pc_write=1) and enters MD_WAIT.
  - MD_WAIT holds until md_done=1. That cycle asserts reg_write=1, rf_wr_sel=3 and md_sel=1.
  - It then follows the same INTR/FETCH exit rule as LD_WAIT.
- Without the macro:
  - The md_* ports are absent.
  - That encoding decodes as illegal_instr=1 with no register write.

Test Plan:
- Reset then hold: RST=1 for 3 cycles → all outputs 0. After release, FETCH gives mem_rden1=1 on cycle 1; with MEM_LAT=1, EXEC follows on cycle 2.
- MEM_LAT=3 load, ir=0x0000A083 (lw x1,0(x1)) → EXEC mem_rden2=1 and pc_write=1, then 2 idle cycles, then reg_write=1 with rf_wr_sel=2. FETCH recurs 4 cycles after EXEC.
- Branches with ir=0x00208463 (beq):
  - br_eq=1 → pcSource=2.
  - br_eq=0 → pcSource=0.
  - Same test with funct3=111 (BGEU): br_ltu=0 → pcSource=2.
- NUM_IRQ=4, mie=1, intr rises on lines 1 and 3 in the same cycle during ADD execution:
  - → INTR follows EXEC with irq_cause=1 and pcSource=4.
  - A second INTR follows the next instruction with irq_cause=3.
- mie=0 with an intr[0] pulse → no trap. Later setting mie=1 → trap after the next EXEC, irq_cause=0.
- ir=0x02208033 (mul) → with OTTER_MEXT_EN, md_start=1 and the FSM waits until md_done before reg_write. Without it, illegal_instr=1 and reg_write=0.
